// File: rtl/id_ex_issue_if.sv
// ID/EX issue bus: decode-side inputs and registered ALU operands/controls.
interface id_ex_issue_if #(
   parameter int n  = 64,
   parameter int CW = 32
);
   logic          Stall;
   logic          Flush;
   logic          InValid;
   logic [31:0]   Instruction;
   logic [n-1:0]  RegA;
   logic [n-1:0]  RegB;
   logic [n-1:0]  BusA;
   logic [n-1:0]  BusB;
   logic [3:0]    ALUCtrl;
   logic          ExValid;
   logic          RegWrite;
   logic          MemRead;
   logic          MemWrite;
   logic [4:0]    Rd;
   logic          Illegal;
   logic [CW-1:0] IssueCount;

   // Issue stage: consumes decode inputs, drives the EX-stage operands.
   modport master (
      input  Stall, Flush, InValid, Instruction, RegA, RegB,
      output BusA, BusB, ALUCtrl, ExValid, RegWrite, MemRead, MemWrite,
             Rd, Illegal, IssueCount
   );

   // Upstream/downstream side: drives decode inputs, observes the issue outputs.
   modport slave (
      output Stall, Flush, InValid, Instruction, RegA, RegB,
      input  BusA, BusB, ALUCtrl, ExValid, RegWrite, MemRead, MemWrite,
             Rd, Illegal, IssueCount
   );
endinterface

// File: rtl/id_ex_issue.sv
// ID/EX pipeline register with LEGv8 ALU-control decode, stall/flush and an
// issued-instruction counter.
module id_ex_issue #(
   parameter int n  = 64,
   parameter int CW = 32
) (
   input logic          CLK,
   input logic          Reset,
   id_ex_issue_if.master bus
);

   typedef struct packed {
      logic [n-1:0] bus_a;
      logic [n-1:0] bus_b;
      logic [3:0]   alu_ctrl;
      logic         ex_valid;
      logic         reg_write;
      logic         mem_read;
      logic         mem_write;
      logic [4:0]   rd;
      logic         illegal;
   } ex_t;

   ex_t           dec;
   ex_t           ex_d, ex_q;
   logic [CW-1:0] cnt_d, cnt_q;
   logic [10:0]   opcode;

   assign opcode = bus.Instruction[31:21];

   // Decode the incoming instruction into a candidate EX-stage entry.
   always_comb begin
      // NOTE: default every field first so no path leaves a signal unassigned (no latch).
      dec          = '0;
      dec.bus_a    = bus.RegA;
      dec.rd       = bus.Instruction[4:0];
      dec.ex_valid = 1'b1;
      casez (opcode)
         11'b10001011000: begin  // ADD
            dec.alu_ctrl  = 4'b0010;
            dec.bus_b     = bus.RegB;
            dec.reg_write = 1'b1;
         end
         11'b11001011000: begin  // SUB
            dec.alu_ctrl  = 4'b0110;
            dec.bus_b     = bus.RegB;
            dec.reg_write = 1'b1;
         end
         11'b10001010000: begin  // AND
            dec.alu_ctrl  = 4'b0000;
            dec.bus_b     = bus.RegB;
            dec.reg_write = 1'b1;
         end
         11'b10101010000: begin  // ORR
            dec.alu_ctrl  = 4'b0001;
            dec.bus_b     = bus.RegB;
            dec.reg_write = 1'b1;
         end
         11'b1001000100?: begin  // ADDI
            dec.alu_ctrl  = 4'b0010;
            dec.bus_b     = {{(n-12){1'b0}}, bus.Instruction[21:10]};
            dec.reg_write = 1'b1;
         end
         11'b1101000100?: begin  // SUBI
            dec.alu_ctrl  = 4'b0110;
            dec.bus_b     = {{(n-12){1'b0}}, bus.Instruction[21:10]};
            dec.reg_write = 1'b1;
         end
         11'b11111000010: begin  // LDUR: address = Rn + signed imm9
            dec.alu_ctrl  = 4'b0010;
            dec.bus_b     = {{(n-9){bus.Instruction[20]}}, bus.Instruction[20:12]};
            dec.mem_read  = 1'b1;
            dec.reg_write = 1'b1;
         end
         11'b11111000000: begin  // STUR
            dec.alu_ctrl  = 4'b0010;
            dec.bus_b     = {{(n-9){bus.Instruction[20]}}, bus.Instruction[20:12]};
            dec.mem_write = 1'b1;
         end
         11'b10110100???: begin  // CBZ: ALU passes Rt through for the zero test
            dec.alu_ctrl  = 4'b0111;
            dec.bus_b     = bus.RegB;
         end
         11'b110100101??: begin  // MOVZ: hw shift is applied by the ALU, not here
            dec.alu_ctrl  = {2'b11, bus.Instruction[22:21]};
            dec.bus_a     = '0;
            dec.bus_b     = {{(n-16){1'b0}}, bus.Instruction[20:5]};
            dec.reg_write = 1'b1;
         end
         default: begin
            dec         = '0;
            dec.illegal = 1'b1;
         end
      endcase
   end

   // Select next register contents: flush beats stall, stall beats load.
   always_comb begin
      ex_d  = ex_q;
      cnt_d = cnt_q;
      if (bus.Flush) begin
         ex_d = '0;
      end else if (!bus.Stall) begin
         if (bus.InValid) begin
            ex_d = dec;
            if (dec.ex_valid) cnt_d = cnt_q + 1'b1;
         end else begin
            ex_d = '0;
         end
      end
   end

   // Pipeline register and issue counter, cleared asynchronously.
   always_ff @(posedge CLK or posedge Reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (Reset) begin
         ex_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         cnt_q <= cnt_d;
      end
   end

   assign bus.BusA       = ex_q.bus_a;
   assign bus.BusB       = ex_q.bus_b;
   assign bus.ALUCtrl    = ex_q.alu_ctrl;
   assign bus.ExValid    = ex_q.ex_valid;
   assign bus.RegWrite   = ex_q.reg_write;
   assign bus.MemRead    = ex_q.mem_read;
   assign bus.MemWrite   = ex_q.mem_write;
   assign bus.Rd         = ex_q.rd;
   assign bus.Illegal    = ex_q.illegal;
   assign bus.IssueCount = cnt_q;

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed bench for id_ex_issue: decode table, stall/flush, reset, counter wrap.
module tb_id_ex_issue;
   localparam int N = 64;

   logic CLK = 1'b0;
   logic Reset = 1'b0;
   int   total = 0;
   int   bad = 0;

   id_ex_issue_if #(.n(N), .CW(32)) bus ();
   id_ex_issue_if #(.n(N), .CW(2))  bus_w ();

   id_ex_issue #(.n(N), .CW(32)) u_dut (.CLK(CLK), .Reset(Reset), .bus(bus.master));
   id_ex_issue #(.n(N), .CW(2))  u_dut_w (.CLK(CLK), .Reset(Reset), .bus(bus_w.master));

   always #5 CLK = ~CLK;

   typedef logic [N+N+4+4+5+1+32-1:0] snap_t;

   // Packed snapshot of every main-DUT output.
   function automatic snap_t obs();
      return {bus.BusA, bus.BusB, bus.ALUCtrl, bus.ExValid, bus.RegWrite, bus.MemRead,
              bus.MemWrite, bus.Rd, bus.Illegal, bus.IssueCount};
   endfunction

   function automatic snap_t expv(logic [N-1:0] a, logic [N-1:0] b, logic [3:0] alu,
                                  logic ev, logic rw, logic mr, logic mw,
                                  logic [4:0] rd, logic ill, logic [31:0] cnt);
      return {a, b, alu, ev, rw, mr, mw, rd, ill, cnt};
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(logic v, logic [31:0] ins, logic [N-1:0] a, logic [N-1:0] b);
      bus.InValid     = v;
      bus.Instruction = ins;
      bus.RegA        = a;
      bus.RegB        = b;
   endtask

   task automatic test_reset();
      snap_t e;
      Reset = 1'b1;
      step();
      step();
      e = '0;
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL reset_init: got %h want %h", obs(), e);
      end
      Reset = 1'b0;
   endtask

   task automatic test_add();
      snap_t e;
      drive(1'b1, 32'h8B020020, 64'd5, 64'd7);
      step();
      e = expv(64'd5, 64'd7, 4'b0010, 1, 1, 0, 0, 5'd0, 0, 32'd1);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL add: got %h want %h", obs(), e);
      end
   endtask

   task automatic test_ldur();
      snap_t e;
      drive(1'b1, 32'hF85F8041, 64'h100, 64'h999);
      step();
      e = expv(64'h100, 64'hFFFF_FFFF_FFFF_FFF8, 4'b0010, 1, 1, 1, 0, 5'd1, 0, 32'd2);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL ldur_neg: got %h want %h", obs(), e);
      end
   endtask

   task automatic test_movz();
      snap_t e;
      drive(1'b1, 32'hD2E24681, 64'hDEAD, 64'hBEEF);
      step();
      e = expv(64'd0, 64'h1234, 4'b1111, 1, 1, 0, 0, 5'd1, 0, 32'd3);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL movz: got %h want %h", obs(), e);
      end
   endtask

   task automatic test_reset_midcycle();
      snap_t e;
      drive(1'b0, 32'h0, 64'd0, 64'd0);
      #2;
      Reset = 1'b1;
      #1;
      e = '0;
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL reset_mid: got %h want %h", obs(), e);
      end
      #2;
      Reset = 1'b0;
      step();
   endtask

   task automatic test_alu_ops();
      logic [31:0]  ins [6];
      logic [N-1:0] bb  [6];
      logic [3:0]   alu [6];
      logic [3:0]   ctl [6];  // {RegWrite, MemRead, MemWrite, Rd-nonzero unused}
      logic [4:0]   rd  [6];
      snap_t e;
      ins = '{32'hCB020020, 32'h8A020020, 32'h913FFC05, 32'hD1004002, 32'hF8008004, 32'hB4000047};
      bb  = '{64'h30, 64'h30, 64'hFFF, 64'h10, 64'h8, 64'h30};
      alu = '{4'b0110, 4'b0000, 4'b0010, 4'b0110, 4'b0010, 4'b0111};
      ctl = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0010, 4'b0000};
      rd  = '{5'd0, 5'd0, 5'd5, 5'd2, 5'd4, 5'd7};
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, ins[i], 64'h55, 64'h30);
         step();
         e = expv(64'h55, bb[i], alu[i], 1, ctl[i][3], ctl[i][2], ctl[i][1], rd[i], 0,
                  32'(i + 1));
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL alu_op_%0d: got %h want %h", i, obs(), e);
         end
      end
   endtask

   task automatic test_invalid();
      snap_t e;
      drive(1'b0, 32'h8B020020, 64'd1, 64'd2);
      step();
      e = expv(64'd0, 64'd0, 4'b0000, 0, 0, 0, 0, 5'd0, 0, 32'd6);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL invalid_bubble: got %h want %h", obs(), e);
      end
   endtask

   task automatic test_stall_flush();
      snap_t e;
      drive(1'b1, 32'hAA020023, 64'hA, 64'hB);
      step();
      e = expv(64'hA, 64'hB, 4'b0001, 1, 1, 0, 0, 5'd3, 0, 32'd7);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL orr: got %h want %h", obs(), e);
      end
      bus.Stall = 1'b1;
      drive(1'b1, 32'h8B020020, 64'h77, 64'h88);
      for (int i = 0; i < 2; i++) begin
         step();
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL stall_hold_%0d: got %h want %h", i, obs(), e);
         end
      end
      bus.Flush = 1'b1;
      step();
      e = expv(64'd0, 64'd0, 4'b0000, 0, 0, 0, 0, 5'd0, 0, 32'd7);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL stall_flush: got %h want %h", obs(), e);
      end
      bus.Flush = 1'b0;
      bus.Stall = 1'b0;
   endtask

   task automatic test_illegal();
      snap_t e;
      drive(1'b1, 32'h00000000, 64'h12, 64'h34);
      step();
      e = expv(64'd0, 64'd0, 4'b0000, 0, 0, 0, 0, 5'd0, 1, 32'd7);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL illegal: got %h want %h", obs(), e);
      end
      drive(1'b1, 32'h8B020020, 64'd2, 64'd3);
      step();
      e = expv(64'd2, 64'd3, 4'b0010, 1, 1, 0, 0, 5'd0, 0, 32'd8);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL after_illegal: got %h want %h", obs(), e);
      end
      drive(1'b0, 32'h0, 64'd0, 64'd0);
   endtask

   task automatic test_wrap();
      bus_w.InValid     = 1'b1;
      bus_w.Instruction = 32'h8B020020;
      bus_w.RegA        = 64'd1;
      bus_w.RegB        = 64'd1;
      repeat (3) step();
      total++;
      if (bus_w.IssueCount !== 2'd3) begin
         bad++;
         $display("FAIL wrap_preload: got %0d want 3", bus_w.IssueCount);
      end
      step();
      total++;
      if (bus_w.IssueCount !== 2'd0) begin
         bad++;
         $display("FAIL wrap_zero: got %0d want 0", bus_w.IssueCount);
      end
      bus_w.InValid = 1'b0;
   endtask

   initial begin
      bus.Stall   = 1'b0;
      bus.Flush   = 1'b0;
      drive(1'b0, 32'h0, 64'd0, 64'd0);
      bus_w.Stall       = 1'b0;
      bus_w.Flush       = 1'b0;
      bus_w.InValid     = 1'b0;
      bus_w.Instruction = 32'h0;
      bus_w.RegA        = '0;
      bus_w.RegB        = '0;

      test_reset();
      test_add();
      test_ldur();
      test_movz();
      test_reset_midcycle();
      test_alu_ops();
      test_invalid();
      test_stall_flush();
      test_illegal();
      test_wrap();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/id_ex_issue.md
Name: id_ex_issue

Overview:
- ID/EX pipeline register and ALU-control issue stage: the driving end of the ALU interface.
- Decodes a 32-bit LEGv8 instruction plus register-file read data into registered BusA, BusB and ALUCtrl operands for the EX-stage ALU, together with memory/writeback control bits.
- Supports pipeline stall (hold) and flush (bubble insertion).
- Keeps a count of issued instructions.

Parameters:
- n, 64, datapath width of BusA/BusB/RegA/RegB.
- CW, 32, width of IssueCount.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous active-high reset.
- Stall  input  1  hold all outputs and counter unchanged.
- Flush  input  1  load a bubble on the next edge.
- InValid  input  1  Instruction/RegA/RegB are meaningful this cycle.
- Instruction  input  32  instruction word from IF/ID.
- RegA  input  n  register-file read data 1 (Rn).
- RegB  input  n  register-file read data 2 (Rm or Rt).
- BusA  output  n  ALU operand A.
- BusB  output  n  ALU operand B.
- ALUCtrl  output  4  ALU operation code.
- ExValid  output  1  EX stage holds a real instruction.
- RegWrite  output  1  writeback enable.
- MemRead  output  1  load.
- MemWrite  output  1  store.
- Rd  output  5  destination/Rt field, Instruction[4:0].
- Illegal  output  1  last loaded instruction was undecodable.
- IssueCount  output  CW  count of valid instructions issued.

Behaviour:
- Reset (asynchronous, any time): every output goes to 0, including IssueCount. Reset mid-stall or mid-flush also clears.
- Update priority at each rising edge: Reset > Flush > Stall > Load.
- Flush: outputs take the bubble value. Bubble = all control bits 0, ExValid 0, ALUCtrl 0000, BusA/BusB/Rd 0, Illegal 0. IssueCount is unchanged. Flush with Stall high at the same time: flush wins.
- Stall (Flush low): every output and IssueCount hold their value.
- Load with InValid=0: bubble.
- Load with InValid=1: decode Instruction[31:21] and register the results. Latency is 1 cycle from input to output. BusA = RegA for all decoded instructions.
- Decode table:
  - ADD 10001011000: ALUCtrl 0010, BusB=RegB, RegWrite=1.
  - SUB 11001011000: ALUCtrl 0110, BusB=RegB, RegWrite=1.
  - AND 10001010000: ALUCtrl 0000, BusB=RegB, RegWrite=1.
  - ORR 10101010000: ALUCtrl 0001, BusB=RegB, RegWrite=1.
  - ADDI 1001000100x: ALUCtrl 0010, BusB = zero-extended Instruction[21:10], RegWrite=1.
  - SUBI 1101000100x: ALUCtrl 0110, BusB = zero-extended Instruction[21:10], RegWrite=1.
  - LDUR 11111000010: ALUCtrl 0010, BusB = sign-extended Instruction[20:12] (9-bit), MemRead=1, RegWrite=1.
  - STUR 11111000000: ALUCtrl 0010, BusB = sign-extended Instruction[20:12], MemWrite=1.
  - CBZ 10110100xxx: ALUCtrl 0111 (PassB), BusB=RegB, no write, no memory access.
  - MOVZ 110100101xx: ALUCtrl = {2'b11, Instruction[22:21]}, BusB = zero-extended Instruction[20:5] (16-bit), BusA=0, RegWrite=1. The ALU applies the hw*16 shift; this block does not shift.
- Decode match is exact on the listed bits; x bits are don't-care.
- Any other opcode: Illegal=1, ExValid=0, all control bits 0, ALUCtrl 0000, BusA/BusB/Rd 0. IssueCount is unchanged.
- Decoded instruction: ExValid=1, Illegal=0, Rd=Instruction[4:0], IssueCount increments by 1.
- IssueCount wraps from 2^CW-1 to 0 with no flag.
- Stall + InValid=1: the input instruction is not consumed. The upstream stage holds it.

Test Plan:
- Reset during operation: assert Reset mid-cycle after 3 issues -> all outputs 0 immediately (before the next edge), IssueCount=0.
- ADD: Instruction=0x8B020020, RegA=5, RegB=7 -> next edge: BusA=5, BusB=7, ALUCtrl=0010, RegWrite=1, Rd=0, ExValid=1, IssueCount=1.
- LDUR with negative offset: Instruction=0xF85F8041 (imm9=0x1F8) -> BusB=0xFFFFFFFFFFFFFFF8, ALUCtrl=0010, MemRead=1, RegWrite=1, Rd=1.
- MOVZ: Instruction=0xD2E24681 (hw=3, imm16=0x1234) -> ALUCtrl=1111, BusB=0x1234, BusA=0, Rd=1.
- Stall then Flush together: load ORR, then hold Stall=1 for 2 edges -> outputs unchanged; then Stall=1 with Flush=1 -> bubble, IssueCount unchanged.
- Illegal opcode 0x00000000 with InValid=1 -> Illegal=1, ExValid=0, IssueCount unchanged; separately preload IssueCount=2^CW-1 and issue ADD -> IssueCount=0.
